mc_control: RTL and testbench

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle `control` decoder when the core is rebuilt around one shared instruction/data memory, a single ALU, and the IR/MDR/A/B/ALUOut holding registers. It walks each instruction through fetch, decode, execute, memory and write-back states. It stalls on a memory ready handshake and emits every mux select and write enable for the datapath.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_control_out_decode.sv | 119 +++++++++++
 rtl/mc_control.sv | 98 +++++++++
 tb/tb_mc_control.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS sequencer.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTEXE   = 4'd6,
    RTWB    = 4'd7,
    ADDIEXE = 4'd8,
    ADDIWB  = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Dispatch target leaving DECODE; unsupported opcodes restart at FETCH.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:   dispatch = MEMADR;
      OP_RTYPE:       dispatch = RTEXE;
      OP_ADDI:        dispatch = ADDIEXE;
      OP_BEQ, OP_BNE: dispatch = BRANCH;
      OP_J, OP_JAL:   dispatch = JUMP;
      default:        dispatch = FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_out_decode.sv
// Combinational map from sequencer state, effective opcode and memory handshake
// to every datapath select and strobe.
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal
);

  state_t st;
  assign st = state_t'(state);

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = M2R_ALUOUT;
    RegDst        = RDST_RT;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_B;
    ALUOp         = ALU_ADD;
    PCSource      = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (st)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        if (!is_legal(op)) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = M2R_MDR;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      RTEXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = RDST_RD;
        instr_done = 1'b1;
      end
      ADDIEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALU_SUB;
        PCSource      = PCSRC_ALUOUT;
        PCWriteCond   = (op == OP_BEQ);
        PCWriteCondNe = (op == OP_BNE);
        instr_done    = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        // jal links PC+4, which PC already holds after FETCH.
        if (op == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = RDST_RA;
          MemtoReg = M2R_PC;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS sequencer: state and opcode registers plus next-state logic;
// output decode lives in mc_out_decode.
module mc_control
  import mc_pkg::*;
(
  input  logic       clock,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic [5:0] op_eff;

  logic pc_write_d, pc_cond_d, pc_cond_ne_d, mem_read_d, mem_write_d;
  logic ir_write_d, reg_write_d, done_d, illegal_d;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE:  state_d = dispatch(opcode);
      MEMADR:  state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWR:   if (mem_ready) state_d = FETCH;
      RTEXE:   state_d = RTWB;
      ADDIEXE: state_d = ADDIWB;
      MEMWB, RTWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // DECODE sees the live opcode; every later state uses the latched copy.
  assign op_eff = (state_q == DECODE) ? opcode : op_q;

  mc_out_decode u_out_decode (
    .state         (state_q),
    .op            (op_eff),
    .mem_ready     (mem_ready),
    .PCWrite       (pc_write_d),
    .PCWriteCond   (pc_cond_d),
    .PCWriteCondNe (pc_cond_ne_d),
    .IorD          (IorD),
    .MemRead       (mem_read_d),
    .MemWrite      (mem_write_d),
    .IRWrite       (ir_write_d),
    .MemtoReg      (MemtoReg),
    .RegDst        (RegDst),
    .RegWrite      (reg_write_d),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .PCSource      (PCSource),
    .instr_done    (done_d),
    .illegal       (illegal_d)
  );

  // Strobes are squashed combinationally so a reset mid-write takes effect at once.
  assign PCWrite       = Reset & pc_write_d;
  assign PCWriteCond   = Reset & pc_cond_d;
  assign PCWriteCondNe = Reset & pc_cond_ne_d;
  assign MemRead       = Reset & mem_read_d;
  assign MemWrite      = Reset & mem_write_d;
  assign IRWrite       = Reset & ir_write_d;
  assign RegWrite      = Reset & reg_write_d;
  assign instr_done    = Reset & done_d;
  assign illegal       = Reset & illegal_d;
  assign state         = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control against a per-signal reference model.
module tb_mc_control;
  import mc_pkg::*;

  logic       clock = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, PCSource;
  logic       RegWrite, ALUSrcA, instr_done, illegal;
  logic [3:0] ALUOp, state;

  int tests = 0;
  int fails = 0;
  int done_cnt;

  typedef struct packed {
    logic       pcw, pcwc, pcwcn, iord, mrd, mwr, irw;
    logic [1:0] m2r, rdst;
    logic       rw, srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       done, ill;
    logic [3:0] st;
  } ov_t;

  typedef struct {
    state_t st;
    logic   rdy;
  } step_t;

  mc_control dut (
    .clock(clock), .Reset(Reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  function automatic ov_t sample();
    ov_t o;
    o = '{PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
          MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
          instr_done, illegal, state};
    return o;
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000101, 6'b001000, 6'b000010, 6'b000011};
  endfunction

  // Reference: each output written as its own predicate over the step.
  function automatic ov_t model(input state_t st, input logic [5:0] op, input logic rdy);
    ov_t e;
    logic jal;
    jal     = (op == 6'b000011);
    e.st    = st;
    e.pcw   = (st == FETCH && rdy) || st == JUMP;
    e.pcwc  = (st == BRANCH) && op == 6'b000100;
    e.pcwcn = (st == BRANCH) && op == 6'b000101;
    e.iord  = st inside {MEMRD, MEMWR};
    e.mrd   = st inside {FETCH, MEMRD};
    e.mwr   = (st == MEMWR);
    e.irw   = (st == FETCH) && rdy;
    e.rw    = st inside {MEMWB, RTWB, ADDIWB} || (st == JUMP && jal);
    e.m2r   = (st == MEMWB) ? 2'b01 : (st == JUMP && jal) ? 2'b10 : 2'b00;
    e.rdst  = (st == RTWB) ? 2'b01 : (st == JUMP && jal) ? 2'b10 : 2'b00;
    e.srca  = st inside {MEMADR, RTEXE, ADDIEXE, BRANCH};
    e.srcb  = (st == FETCH) ? 2'b01 : (st == DECODE) ? 2'b11 :
              (st inside {MEMADR, ADDIEXE}) ? 2'b10 : 2'b00;
    e.aluop = (st == RTEXE) ? 4'b0010 : (st == BRANCH) ? 4'b0001 : 4'b0000;
    e.pcsrc = (st == BRANCH) ? 2'b01 : (st == JUMP) ? 2'b10 : 2'b00;
    e.ill   = (st == DECODE) && !legal_op(op);
    e.done  = st inside {MEMWB, RTWB, ADDIWB, BRANCH, JUMP} ||
              (st == MEMWR && rdy) || e.ill;
    return e;
  endfunction

  function automatic ov_t reset_vec();
    ov_t e;
    e = '0;
    e.srcb = 2'b01;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input state_t st, input logic [5:0] op, input logic rdy);
    ov_t o;
    @(negedge clock);
    mem_ready = rdy;
    opcode    = (st == DECODE) ? op : 6'($urandom);
    #1;
    o = sample();
    if (o.done) done_cnt++;
    check($sformatf("%s op=%b rdy=%0b", st.name(), op, rdy), 32'(o), 32'(model(st, op, rdy)));
  endtask

  // Builds the cycle-by-cycle path an instruction takes, then steps through it.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    step_t q[$];
    q = {};
    for (int i = 0; i < fs; i++) q.push_back('{FETCH, 1'b0});
    q.push_back('{FETCH, 1'b1});
    q.push_back('{DECODE, 1'($urandom)});
    if (op == 6'b100011) begin
      q.push_back('{MEMADR, 1'($urandom)});
      for (int i = 0; i < ms; i++) q.push_back('{MEMRD, 1'b0});
      q.push_back('{MEMRD, 1'b1});
      q.push_back('{MEMWB, 1'($urandom)});
    end else if (op == 6'b101011) begin
      q.push_back('{MEMADR, 1'($urandom)});
      for (int i = 0; i < ms; i++) q.push_back('{MEMWR, 1'b0});
      q.push_back('{MEMWR, 1'b1});
    end else if (op == 6'b000000) begin
      q.push_back('{RTEXE, 1'($urandom)});
      q.push_back('{RTWB, 1'($urandom)});
    end else if (op == 6'b001000) begin
      q.push_back('{ADDIEXE, 1'($urandom)});
      q.push_back('{ADDIWB, 1'($urandom)});
    end else if (op inside {6'b000100, 6'b000101}) begin
      q.push_back('{BRANCH, 1'($urandom)});
    end else if (op inside {6'b000010, 6'b000011}) begin
      q.push_back('{JUMP, 1'($urandom)});
    end
    done_cnt = 0;
    foreach (q[i]) step(q[i].st, op, q[i].rdy);
    check($sformatf("done_pulses op=%b", op), 32'(done_cnt), 32'd1);
  endtask

  logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000101, 6'b001000, 6'b000010, 6'b000011};

  initial begin
    logic [5:0] op;
    ov_t o;
    Reset = 1'b0; mem_ready = 1'b1; opcode = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1 check("reset_outputs", 32'(sample()), 32'(reset_vec()));
    end
    mem_ready = 1'b0;
    Reset = 1'b1;

    // Directed sequences
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 2);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b000011, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 1, 0);
    run_instr(6'b100011, 2, 3);

    // Reset dropped while RTWB is writing the register file
    done_cnt = 0;
    step(FETCH, 6'b000000, 1'b1);
    step(DECODE, 6'b000000, 1'b0);
    step(RTEXE, 6'b000000, 1'b0);
    step(RTWB, 6'b000000, 1'b1);
    #1 Reset = 1'b0;
    #1 o = sample();
    check("reset_rtwb_regwrite", 32'(o.rw), 32'd0);
    check("reset_rtwb_vector", 32'(o), 32'(reset_vec()));
    @(negedge clock);
    mem_ready = 1'b0;
    Reset = 1'b1;
    #1 check("post_reset_fetch", 32'(sample()), 32'(model(FETCH, 6'b000000, 1'b0)));

    // Randomized instruction stream with random stalls
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    step(FETCH, 6'b000000, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
